// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: staggered multi-domain reset sequencer plus run watchdog.
// Holds N_DOM reset domains for a programmable count, releases them in order,
// then supervises the run until halt, commit stall or cycle budget, while
// counting RUN cycles and commits for CPI reporting.
module sim_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 25,
  parameter int unsigned N_DOM       = 2,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned CNT_W       = 40,
  parameter logic [63:0] TIMEOUT     = 64'd150_000_000_000,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             halt_in,
  input  logic             commit_in,
  output logic [N_DOM-1:0] dom_rst_out,
  output logic             run_out,
  output logic             done_out,
  output logic [1:0]       status_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [CNT_W-1:0] commit_cnt_out
);

  // Edge number on which the last domain is released and RUN begins.
  localparam int unsigned HOLD_MAX = RST_CYCLES + (N_DOM - 1) * STAGGER;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  // With stall detection disabled the stall counter is a single idle bit.
  localparam int unsigned STALL_W  = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(HOLD_MAX);
  localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_STALL   = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   commit_q, commit_d;
  logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  // Next-state and next-counter logic for the HOLD/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    status_d  = status_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    cycle_d   = cycle_q;
    commit_d  = commit_q;
    dom_rst_d = dom_rst_q;
    hold_inc  = hold_q + HOLD_W'(1);

    case (state_q)
      S_HOLD: begin
        // hold_inc is the number of the edge being taken; domain i drops
        // once that number reaches its release point.
        hold_d = hold_inc;
        for (int i = 0; i < N_DOM; i++) begin
          dom_rst_d[i] = (hold_inc < HOLD_W'(RST_CYCLES + i * STAGGER));
        end
        if (hold_inc == HOLD_LAST) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // The terminating edge still counts its own cycle and commit.
        cycle_d  = cycle_q + CNT_W'(1);
        commit_d = commit_q + CNT_W'(commit_in);
        if (commit_in || (STALL_LIMIT == 0)) begin
          stall_d = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end

        // Priority: halt beats stall beats timeout.
        if (halt_in) begin
          state_d  = S_DONE;
          status_d = ST_HALT;
        end else if ((STALL_LIMIT != 0) && (stall_d == STALL_LAST)) begin
          state_d  = S_DONE;
          status_d = ST_STALL;
        end else if ((TIMEOUT != 64'd0) && (cycle_d == TIMEOUT_LAST)) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end

      S_DONE: begin
        // Frozen until rst_in; domains stay released for post-run inspection.
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase

    run_d  = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q   <= S_HOLD;
      status_q  <= ST_NONE;
      hold_q    <= '0;
      stall_q   <= '0;
      cycle_q   <= '0;
      commit_q  <= '0;
      dom_rst_q <= '1;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      hold_q    <= hold_d;
      stall_q   <= stall_d;
      cycle_q   <= cycle_d;
      commit_q  <= commit_d;
      dom_rst_q <= dom_rst_d;
      run_q     <= run_d;
      done_q    <= done_d;
    end
  end

  assign dom_rst_out    = dom_rst_q;
  assign run_out        = run_q;
  assign done_out       = done_q;
  assign status_out     = status_q;
  assign cycle_cnt_out  = cycle_q;
  assign commit_cnt_out = commit_q;

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised reset sequencer and run watchdog for the RISC-V CPU simulation and FPGA top level. It replaces fixed-length reset stretching and a wall-clock timeout with a single clocked block. The block holds N_DOM reset domains (core, cache/memory controller, UART, ...) for a programmable count and releases them in a staggered order. It then supervises the run, ending it on program halt, lack of commit progress, or a cycle budget, and exposes cycle and commit counters for CPI reporting.

## Interface
- RST_CYCLES, 25: cycles domain 0 stays in reset after rst_in drops; must be ≥1
- N_DOM, 2: number of reset domains; must be ≥1
- STAGGER, 4: extra cycles between releases of consecutive domains; 0 releases all domains together
- CNT_W, 40: width of the cycle and commit counters
- TIMEOUT, 150_000_000_000: RUN-cycle budget; 0 disables the timeout
- STALL_LIMIT, 1024: consecutive RUN cycles without commit_in before the stall abort; 0 disables stall detection
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  synchronous, active-high reset
- halt_in  input  1  program end signalled by the CPU (ebreak/store to the halt address)
- commit_in  input  1  one instruction retired this cycle
- dom_rst_out  output  N_DOM  per-domain reset, active-high
- run_out  output  1  all domains released and run in progress
- done_out  output  1  run ended; sticky
- status_out  output  2  00 not finished, 01 halted, 10 stalled, 11 timed out
- cycle_cnt_out  output  CNT_W  number of RUN cycles
- commit_cnt_out  output  CNT_W  number of commits during RUN

## Operation
- States: HOLD, RUN, DONE.
- While rst_in=1 (sampled at the edge): state HOLD; all internal counters 0.
  - Outputs: dom_rst_out all ones, run_out=0, done_out=0, status_out=00, cycle_cnt_out=0, commit_cnt_out=0.
- HOLD counting:
  - The hold counter increments on every edge with rst_in=0.
  - Number the first such edge 1.
  - dom_rst_out[i] goes to 0 after edge RST_CYCLES + i*STAGGER.
- HOLD→RUN: on the same edge that releases dom_rst_out[N_DOM-1]; run_out becomes 1.
- RUN, each edge:
  - cycle_cnt increments.
  - commit_cnt increments if commit_in=1.
  - Stall counter clears on commit_in=1, otherwise increments.
- RUN→DONE conditions, evaluated on the counts including the current edge:
  - halt_in=1 → status 01.
  - Stall counter reaches STALL_LIMIT → status 10.
  - cycle_cnt reaches TIMEOUT → status 11.
  - Priority when several hold on one edge: halt > stall > timeout.
- Terminating edge: still counts its cycle and any commit.
- DONE:
  - Counters freeze.
  - run_out=0, done_out=1.
  - dom_rst_out stays 0, so the CPU is not re-reset and the bench can inspect state.
  - Exit only via rst_in.
- halt_in and commit_in are ignored in HOLD and DONE.
- rst_in=1 in any state, including mid-release or mid-run: next state HOLD, all outputs back to reset values, no partial sequence retained.
- Counter widths:
  - Hold counter sized for RST_CYCLES + (N_DOM-1)*STAGGER.
  - Stall counter sized for STALL_LIMIT.
  - cycle_cnt and commit_cnt wrap modulo 2^CNT_W; wrap is unreachable when TIMEOUT < 2^CNT_W, which is a required parameter constraint.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset release latency: domain i is held for exactly RST_CYCLES + i*STAGGER edges after rst_in is first sampled 0.
- run_out rises together with the last domain release.
- done_out and status_out update on the terminating edge and are visible the following cycle.
- halt_in asserted in the k-th RUN cycle gives cycle_cnt_out=k.

## Test plan
- Release sequence: rst_in=1 for 5 cycles, then 0 (defaults) → dom_rst_out=11 through edge 25, =10 after edge 25, =00 and run_out=1 after edge 29.
- Halt with counting: commit_in=1 every other RUN cycle, halt_in pulse in RUN cycle 10 → done_out=1, status 01, cycle_cnt=10, commit_cnt=5, dom_rst_out stays 00.
- Stall: STALL_LIMIT=8, commit_in held 0 → status 10 after RUN cycle 8, cycle_cnt=8; a repeat with commit_in every 7 cycles never stalls.
- Timeout and priority: TIMEOUT=20, STALL_LIMIT=0 → status 11, cycle_cnt=20; halt_in and timeout on the same edge → status 01; STALL_LIMIT=20 with timeout reached on the same edge → status 10.
- Mid-operation reset and ignored inputs:
  - rst_in pulse during the release (after edge 27) and during RUN → dom_rst_out returns to 11, counters 0, sequence restarts from edge 1.
  - halt_in during HOLD → ignored.
- Parameter corners: N_DOM=1, STAGGER=0, RST_CYCLES=1 → dom_rst_out and run_out change after the first edge with rst_in=0.
